bus_rr_scheduler: RTL
=====================

// Module: bus_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one packet bus among DRVS driver FIFOs.
//  Samples each FIFO's pending flag, pops one packet from the granted FIFO,
//  decodes the destination ID in the packet header and pushes the packet to
//  the target FIFO(s), including broadcast. Sits between the per-driver FIFOs
//  and the bus, in place of the monolithic generator/arbiter.
// PARAMETERS
//  WIDTH      32     packet width in bits; header ID = D_pop[WIDTH-1 -: 8]
//  DRVS       8      number of drivers/FIFOs (2..255)
//  BROADCAST  8'hFF  header ID meaning "deliver to all drivers except source"
// PORTS
//  clk       in   1           system clock, all logic on rising edge
//  reset     in   1           synchronous, active-low reset
//  pndng     in   DRVS        FIFO i has a packet at its head (first-word-fall-through)
//  D_pop     in   DRVS*WIDTH  head data of FIFO i at [i*WIDTH +: WIDTH]
//  pop       out  DRVS        one-hot pop strobe to the granted FIFO
//  push      out  DRVS        push strobe mask to the destination FIFO(s)
//  D_push    out  WIDTH       packet driven to all FIFOs, qualified by push
//  grant_id  out  $clog2(DRVS) index of the current/last granted driver
//  busy      out  1           high in GRANT and DELIVER
//  drop_cnt  out  16          count of dropped packets, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, pop=0, push=0, D_push=0,
//    grant_id=0, busy=0, drop_cnt=0, rr pointer ptr=0. Any transfer in
//    progress is aborted; no push is issued for it.
//  - All outputs come from registers or decode state only; no input->output
//    combinational path.
//  - FSM: IDLE -> GRANT -> DELIVER -> IDLE. Exactly 3 cycles per packet.
//  - IDLE: if |pndng, g = first i with pndng[i], scanning ptr, ptr+1, ...
//    wrapping at DRVS-1 -> 0; register grant_id<=g, go GRANT. Else stay.
//  - GRANT: pop[grant_id]=1 for exactly this cycle; capture
//    data<=D_pop[grant_id] at the same edge. pndng deasserting in GRANT is
//    ignored; the packet is still popped and delivered.
//  - DELIVER: D_push=data, push=dest mask for this cycle only;
//    ptr<=(grant_id==DRVS-1)?0:grant_id+1; go IDLE.
//  - Dest mask: id==BROADCAST -> all ones except bit grant_id;
//    id<DRVS and id!=grant_id -> one-hot(id); else mask=0.
//  - Drop: mask==0 (id>=DRVS non-broadcast, or id==source) -> push stays 0
//    and drop_cnt increments by 1 in DELIVER, saturating at 16'hFFFF.
//  - pop and push are never high in the same cycle. Requests arriving during
//    GRANT/DELIVER wait until the next IDLE.
//  - Fairness: with all pndng held high, grants run 0,1,...,DRVS-1,0,...;
//    each driver waits at most DRVS*3 cycles.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with pndng='1 -> pop=0, push=0,
//    busy=0, drop_cnt=0 throughout.
//  2 Unicast: pndng=8'b0000_0100, D_pop[2]=32'h05AB_CDEF -> pop=8'h04 one
//    cycle after IDLE, next cycle push=8'h20, D_push=32'h05AB_CDEF.
//  3 Broadcast: driver 3 sends 32'hFF00_0001 -> single DELIVER cycle with
//    push=8'hF7, D_push=32'hFF00_0001.
//  4 Round robin: pndng=8'hFF held 24 cycles -> grant_id 0..7 in order,
//    one pop every 3 cycles, then wraps to 0.
//  5 Drops: dest 8'h09 from drv 0, dest 8'h01 from drv 1 -> push=0 in both
//    DELIVER cycles, drop_cnt=2. Force drop_cnt to 16'hFFFF, drop again ->
//    stays 16'hFFFF.
//  6 Reset in GRANT: reset=0 while pop is high -> next cycle push=0, state
//    IDLE, ptr=0, and the packet is never delivered.

Source files
------------

// File: rtl/bus_rr_scheduler_if.sv
// Packet-bus signals between the per-driver FIFOs and the round-robin scheduler.
// master = scheduler side, slave = FIFO side.
interface bus_rr_scheduler_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DRVS  = 8
);
  logic [DRVS-1:0]       pndng;
  logic [DRVS*WIDTH-1:0] D_pop;
  logic [DRVS-1:0]       pop;
  logic [DRVS-1:0]       push;
  logic [WIDTH-1:0]      D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler: grants one driver FIFO, pops its head packet and pushes
// it to the FIFO(s) named by the header ID (unicast or broadcast).
module bus_rr_scheduler #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DRVS      = 8,
  parameter logic [7:0]  BROADCAST = 8'hFF,
  localparam int unsigned IdW      = (DRVS > 1) ? $clog2(DRVS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_rr_scheduler_if.master   bus,
  output logic [IdW-1:0]       grant_id,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StDeliver} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             req_found;
  logic [IdW-1:0]   req_sel;
  logic [7:0]       hdr_id;
  logic [DRVS-1:0]  dest_mask;

  function automatic logic [IdW-1:0] wrap_idx(input logic [IdW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= int'(DRVS)) s = s - int'(DRVS);
    return IdW'(s);
  endfunction

  // First pending driver at or after the rr pointer, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    for (int k = 0; k < int'(DRVS); k++) begin
      if (!req_found && bus.pndng[wrap_idx(ptr_q, k)]) begin
        req_found = 1'b1;
        req_sel   = wrap_idx(ptr_q, k);
      end
    end
  end

  // Broadcast goes everywhere but the source; a self-addressed packet yields an empty mask.
  assign hdr_id = data_q[WIDTH-1 -: 8];
  always_comb begin
    dest_mask = '0;
    for (int j = 0; j < int'(DRVS); j++) begin
      dest_mask[j] = ((hdr_id == BROADCAST) || (hdr_id == 8'(j))) && (grant_q != IdW'(j));
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    bus.pop    = '0;
    bus.push   = '0;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          grant_d = req_sel;
          state_d = StGrant;
        end
      end
      StGrant: begin
        bus.pop[grant_q] = 1'b1;
        for (int i = 0; i < int'(DRVS); i++) begin
          if (grant_q == IdW'(i)) data_d = bus.D_pop[i*WIDTH +: WIDTH];
        end
        state_d = StDeliver;
      end
      StDeliver: begin
        bus.push = dest_mask;
        if (dest_mask == '0 && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        ptr_d   = (grant_q == IdW'(DRVS - 1)) ? '0 : grant_q + IdW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.D_push = data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != StIdle);
  assign drop_cnt   = drop_cnt_q;

endmodule
